// File: rtl/uart_stream_mux.sv
// uart_stream_mux
//   Merges NUM_CH independent byte streams onto the single transmit port of
//   the uart block. Each channel owns a DEPTH-entry FIFO of {last, data}. A
//   round-robin arbiter hands out one uart transmit slot at a time, always
//   leaving at least one idle cycle between tx_req pulses.
//
//   Optional feature macro: STREAM_MUX_PKTLOCK_EN
//     When defined, a channel that issues a byte with last=0 keeps the link
//     (LOCK state) until it issues its last=1 byte, so packets never
//     interleave. When undefined, arbitration is per byte and in_last is
//     stored but not acted on.
//
// Ports
//   clk, reset  system clock, synchronous active-high reset
//   ch_en       per-channel arbitration enable (writes still accepted)
//   in_valid    per-channel byte valid
//   in_data     per-channel byte, channel i at [8i+7:8i]
//   in_last     per-channel end-of-packet marker
//   in_ready    per-channel FIFO not full (low while reset is high)
//   tx_byte     byte presented to uart, held between requests
//   tx_req      one-cycle transmit request to uart
//   tx_busy     uart transmitter busy
//   grant_ch    channel that sourced the most recent tx_req
//   idle        nothing buffered, nothing in flight, no packet lock
module uart_stream_mux #(
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 16,
  parameter int CHW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_CH-1:0]   ch_en,
  input  logic [NUM_CH-1:0]   in_valid,
  input  logic [8*NUM_CH-1:0] in_data,
  input  logic [NUM_CH-1:0]   in_last,
  output logic [NUM_CH-1:0]   in_ready,
  output logic [7:0]          tx_byte,
  output logic                tx_req,
  input  logic                tx_busy,
  output logic [CHW-1:0]      grant_ch,
  output logic                idle
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [0:0] {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  // FIFO storage and pointers (one extra pointer bit separates full from empty)
  logic [8:0]        mem_r    [NUM_CH][DEPTH];
  logic [PW-1:0]     wr_ptr_r [NUM_CH];
  logic [PW-1:0]     rd_ptr_r [NUM_CH];
  logic [PW-1:0]     count_s  [NUM_CH];
  logic [NUM_CH-1:0] nonempty_s;
  logic [NUM_CH-1:0] eligible_s;
  logic [NUM_CH-1:0] wr_s;
  logic [NUM_CH-1:0] pop_s;

  // Arbitration / output state
  state_t         state_r, state_nxt_s;
  logic [CHW-1:0] rr_ptr_r, rr_ptr_nxt_s;
  logic           tx_req_r, tx_req_nxt_s;
  logic [7:0]     tx_byte_r, tx_byte_nxt_s;
  logic [CHW-1:0] grant_ch_r, grant_ch_nxt_s;
  logic           sel_found_s;
  logic [CHW-1:0] sel_ch_s;
  logic           issue_s;
  logic [CHW-1:0] issue_ch_s;
  logic [8:0]     head_s;
`ifdef STREAM_MUX_PKTLOCK_EN
  logic [CHW-1:0] lock_ch_r, lock_ch_nxt_s;
`else
  logic           unused_last_s;
  assign unused_last_s = head_s[8];
`endif

  // Per-channel occupancy, write acceptance and eligibility
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      count_s[i]    = wr_ptr_r[i] - rd_ptr_r[i];
      nonempty_s[i] = (count_s[i] != {PW{1'b0}});
      // Registered count only: a full FIFO refuses a write even while popping.
      in_ready[i]   = (count_s[i] < PW'(DEPTH)) && !reset;
      wr_s[i]       = in_valid[i] && in_ready[i];
      eligible_s[i] = nonempty_s[i] && ch_en[i];
    end
  end

  // Round-robin search starting one past the last granted channel
  always_comb begin : arb_search
    int idx;
    idx         = 0;
    sel_found_s = 1'b0;
    sel_ch_s    = {CHW{1'b0}};
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(rr_ptr_r) + k) % NUM_CH;
      if (!sel_found_s && eligible_s[idx]) begin
        sel_found_s = 1'b1;
        sel_ch_s    = CHW'(idx);
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // FSM next state, issue decision and next output values
  always_comb begin
    state_nxt_s    = state_r;
    rr_ptr_nxt_s   = rr_ptr_r;
    tx_req_nxt_s   = 1'b0;
    tx_byte_nxt_s  = tx_byte_r;
    grant_ch_nxt_s = grant_ch_r;
    issue_s        = 1'b0;
    issue_ch_s     = sel_ch_s;
`ifdef STREAM_MUX_PKTLOCK_EN
    lock_ch_nxt_s  = lock_ch_r;
`endif
    case (state_r)
      ST_ARB: begin
        issue_ch_s = sel_ch_s;
        // tx_req_r blocks issue so the uart gets a cycle to raise tx_busy.
        issue_s    = !tx_busy && !tx_req_r && sel_found_s;
      end
`ifdef STREAM_MUX_PKTLOCK_EN
      ST_LOCK: begin
        // Locked channel ignores ch_en; it simply waits for more data.
        issue_ch_s = lock_ch_r;
        issue_s    = !tx_busy && !tx_req_r && nonempty_s[lock_ch_r];
      end
`endif
      default: begin
        state_nxt_s = ST_ARB;
      end
    endcase
    head_s = mem_r[issue_ch_s][rd_ptr_r[issue_ch_s][AW-1:0]];
    if (issue_s) begin
      tx_req_nxt_s   = 1'b1;
      tx_byte_nxt_s  = head_s[7:0];
      grant_ch_nxt_s = issue_ch_s;
      rr_ptr_nxt_s   = issue_ch_s;
`ifdef STREAM_MUX_PKTLOCK_EN
      lock_ch_nxt_s  = issue_ch_s;
      state_nxt_s    = head_s[8] ? ST_ARB : ST_LOCK;
`endif
    end else begin
      tx_req_nxt_s = 1'b0;
    end
  end

  // Pop strobe for the channel being issued
  always_comb begin
    pop_s = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      pop_s[i] = issue_s && (issue_ch_s == CHW'(i));
    end
  end

  // FIFO data array (no reset needed, pointers qualify contents)
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (wr_s[i]) begin
        mem_r[i][wr_ptr_r[i][AW-1:0]] <= {in_last[i], in_data[8*i +: 8]};
      end
    end
  end

  // FIFO pointers; reset flushes every channel
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (reset) begin
        wr_ptr_r[i] <= {PW{1'b0}};
        rd_ptr_r[i] <= {PW{1'b0}};
      end else begin
        if (wr_s[i]) begin
          wr_ptr_r[i] <= wr_ptr_r[i] + PW'(1);
        end
        if (pop_s[i]) begin
          rd_ptr_r[i] <= rd_ptr_r[i] + PW'(1);
        end
      end
    end
  end

  // FSM state, round-robin pointer and registered uart-side outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_ARB;
      rr_ptr_r   <= CHW'(NUM_CH - 1);
      tx_req_r   <= 1'b0;
      tx_byte_r  <= 8'h00;
      grant_ch_r <= {CHW{1'b0}};
`ifdef STREAM_MUX_PKTLOCK_EN
      lock_ch_r  <= {CHW{1'b0}};
`endif
    end else begin
      state_r    <= state_nxt_s;
      rr_ptr_r   <= rr_ptr_nxt_s;
      tx_req_r   <= tx_req_nxt_s;
      tx_byte_r  <= tx_byte_nxt_s;
      grant_ch_r <= grant_ch_nxt_s;
`ifdef STREAM_MUX_PKTLOCK_EN
      lock_ch_r  <= lock_ch_nxt_s;
`endif
    end
  end

  assign tx_req   = tx_req_r;
  assign tx_byte  = tx_byte_r;
  assign grant_ch = grant_ch_r;
  assign idle     = !(|nonempty_s) && !tx_req_r && !tx_busy && (state_r == ST_ARB);

endmodule

// File: tb/tb_uart_stream_mux.sv
// tb_uart_stream_mux
//   Directed bench for uart_stream_mux (NUM_CH=2, DEPTH=16). A small uart
//   model records every tx_req with its byte, grant and cycle number and can
//   hold tx_busy for a fixed number of cycles per byte.
module tb_uart_stream_mux;

  localparam int NUM_CH = 2;
  localparam int DEPTH  = 16;
  localparam int CHW    = 1;

  logic                clk;
  logic                reset;
  logic [NUM_CH-1:0]   ch_en;
  logic [NUM_CH-1:0]   in_valid;
  logic [8*NUM_CH-1:0] in_data;
  logic [NUM_CH-1:0]   in_last;
  logic [NUM_CH-1:0]   in_ready;
  logic [7:0]          tx_byte;
  logic                tx_req;
  logic                tx_busy;
  logic [CHW-1:0]      grant_ch;
  logic                idle;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  logic [7:0]     rx_q[$];
  int             rx_cyc[$];
  logic [CHW-1:0] rx_gnt[$];

  bit force_busy  = 1'b0;
  bit model_en    = 1'b0;
  bit model_busy  = 1'b0;
  int busy_cycles = 3;
  int busy_cnt    = 0;

  assign tx_busy = force_busy | model_busy;

  uart_stream_mux #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .CHW(CHW)) dut (
    .clk      (clk),
    .reset    (reset),
    .ch_en    (ch_en),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_ready (in_ready),
    .tx_byte  (tx_byte),
    .tx_req   (tx_req),
    .tx_busy  (tx_busy),
    .grant_ch (grant_ch),
    .idle     (idle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // uart model: records requests and optionally stays busy per byte
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (tx_req === 1'b1) begin
        rx_q.push_back(tx_byte);
        rx_cyc.push_back(cyc);
        rx_gnt.push_back(grant_ch);
      end
      if (!model_en) begin
        model_busy = 1'b0;
        busy_cnt   = 0;
      end else if (tx_req === 1'b1) begin
        model_busy = 1'b1;
        busy_cnt   = busy_cycles;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) model_busy = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_rx();
    rx_q.delete();
    rx_cyc.delete();
    rx_gnt.delete();
  endtask

  task automatic write_ch(input int ch, input logic [7:0] d, input logic l);
    int guard;
    guard = 0;
    while (in_ready[ch] !== 1'b1 && guard < 200) begin
      tick();
      guard++;
    end
    if (guard >= 200) begin
      $display("FAIL write_wait ch%0d: in_ready=%b required 1 within 200 cycles", ch, in_ready[ch]);
      n_checks++;
      n_errors++;
    end
    in_valid[ch]       = 1'b1;
    in_data[8*ch +: 8] = d;
    in_last[ch]        = l;
    tick();
    in_valid[ch] = 1'b0;
  endtask

  task automatic write_pair(input logic [7:0] d0, input logic l0,
                            input logic [7:0] d1, input logic l1);
    in_valid = 2'b11;
    in_data  = {d1, d0};
    in_last  = {l1, l0};
    tick();
    in_valid = 2'b00;
  endtask

  task automatic wait_rx(input int n, input int limit, input string name);
    int guard;
    guard = 0;
    while (rx_q.size() < n && guard < limit) begin
      tick();
      guard++;
    end
    if (rx_q.size() < n) begin
      $display("FAIL %s timeout: got %0d bytes required %0d", name, rx_q.size(), n);
      n_checks++;
      n_errors++;
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    ch_en    = 2'b11;
    in_valid = 2'b11;
    in_data  = 16'hA55A;
    in_last  = 2'b11;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (in_ready !== 2'b00) begin
        $display("FAIL reset_in_ready: got %b required 00", in_ready); n_errors++;
      end
      n_checks++;
      if (tx_req !== 1'b0) begin
        $display("FAIL reset_tx_req: got %b required 0", tx_req); n_errors++;
      end
      n_checks++;
      if (tx_byte !== 8'h00) begin
        $display("FAIL reset_tx_byte: got %h required 00", tx_byte); n_errors++;
      end
    end
    in_valid = 2'b00;
    reset    = 1'b0;
    tick();
    n_checks++;
    if (idle !== 1'b1) begin
      $display("FAIL reset_idle: got %b required 1", idle); n_errors++;
    end
    n_checks++;
    if (in_ready !== 2'b11) begin
      $display("FAIL post_reset_in_ready: got %b required 11", in_ready); n_errors++;
    end
    n_checks++;
    if (grant_ch !== 1'b0) begin
      $display("FAIL reset_grant: got %0d required 0", grant_ch); n_errors++;
    end
  endtask

  task automatic test_single();
    int w;
    ch_en = 2'b01;
    clear_rx();
    write_ch(0, 8'hA5, 1'b1);
    w = cyc;
    write_ch(0, 8'h5A, 1'b1);
    wait_rx(2, 20, "single");
    repeat (3) tick();
    n_checks++;
    if (rx_q.size() !== 2 || rx_q[0] !== 8'hA5 || rx_q[1] !== 8'h5A) begin
      $display("FAIL single_bytes: got %0d bytes %h %h required A5 5A", rx_q.size(), rx_q[0], rx_q[1]); n_errors++;
    end
    n_checks++;
    if (rx_cyc[0] - w !== 1) begin
      $display("FAIL single_latency: got %0d required 1", rx_cyc[0] - w); n_errors++;
    end
    n_checks++;
    if (rx_cyc[1] - rx_cyc[0] !== 2) begin
      $display("FAIL single_spacing: got %0d required 2", rx_cyc[1] - rx_cyc[0]); n_errors++;
    end
    n_checks++;
    if (rx_gnt[0] !== 1'b0 || rx_gnt[1] !== 1'b0) begin
      $display("FAIL single_grant: got %0d %0d required 0 0", rx_gnt[0], rx_gnt[1]); n_errors++;
    end
    n_checks++;
    if (idle !== 1'b1) begin
      $display("FAIL single_idle: got %b required 1", idle); n_errors++;
    end
  endtask

  task automatic test_fill();
    int g;
    logic [7:0] exp_b;
    ch_en      = 2'b10;
    force_busy = 1'b1;
    clear_rx();
    for (int i = 0; i < DEPTH; i++) write_ch(1, 8'(8'h30 + i), 1'b1);
    n_checks++;
    if (in_ready[1] !== 1'b0) begin
      $display("FAIL fill_full: in_ready[1] got %b required 0", in_ready[1]); n_errors++;
    end
    in_valid[1]   = 1'b1;
    in_data[15:8] = 8'h40;
    repeat (3) tick();
    n_checks++;
    if (in_ready[1] !== 1'b0 || rx_q.size() !== 0) begin
      $display("FAIL fill_held: in_ready[1]=%b sent=%0d required 0 0", in_ready[1], rx_q.size()); n_errors++;
    end
    force_busy = 1'b0;
    g = 0;
    while (in_ready[1] !== 1'b1 && g < 20) begin
      tick();
      g++;
    end
    tick();
    in_valid[1] = 1'b0;
    wait_rx(DEPTH + 1, 200, "fill");
    for (int i = 0; i <= DEPTH; i++) begin
      exp_b = (i == DEPTH) ? 8'h40 : 8'(8'h30 + i);
      n_checks++;
      if (rx_q[i] !== exp_b || rx_gnt[i] !== 1'b1) begin
        $display("FAIL fill_order[%0d]: got %h ch%0d required %h ch1", i, rx_q[i], rx_gnt[i], exp_b); n_errors++;
      end
    end
  endtask

  task automatic test_round_robin();
    logic [7:0]     exp_b [5];
    logic [CHW-1:0] exp_g [5];
    exp_b = '{8'h01, 8'h11, 8'h02, 8'h12, 8'h03};
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    ch_en       = 2'b11;
    model_en    = 1'b1;
    busy_cycles = 10;
    clear_rx();
    write_pair(8'h01, 1'b1, 8'h11, 1'b1);
    write_pair(8'h02, 1'b1, 8'h12, 1'b1);
    write_ch(0, 8'h03, 1'b1);
    wait_rx(5, 300, "round_robin");
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (rx_q[i] !== exp_b[i] || rx_gnt[i] !== exp_g[i]) begin
        $display("FAIL rr_order[%0d]: got %h ch%0d required %h ch%0d", i, rx_q[i], rx_gnt[i], exp_b[i], exp_g[i]); n_errors++;
      end
    end
    repeat (15) tick();
  endtask

  task automatic test_delayed_enable();
    logic [7:0] exp_b [5];
    exp_b = '{8'h01, 8'h02, 8'h21, 8'h03, 8'h22};
    ch_en       = 2'b01;
    model_en    = 1'b1;
    busy_cycles = 3;
    clear_rx();
    write_pair(8'h01, 1'b1, 8'h21, 1'b1);
    write_pair(8'h02, 1'b1, 8'h22, 1'b1);
    write_pair(8'h03, 1'b1, 8'h23, 1'b1);
    write_pair(8'h04, 1'b1, 8'h24, 1'b1);
    write_ch(0, 8'h05, 1'b1);
    write_ch(0, 8'h06, 1'b1);
    wait_rx(2, 100, "delayed_pre");
    n_checks++;
    if (rx_gnt[0] !== 1'b0 || rx_gnt[1] !== 1'b0) begin
      $display("FAIL disabled_ch1_issued: got ch%0d ch%0d required ch0 ch0", rx_gnt[0], rx_gnt[1]); n_errors++;
    end
    ch_en = 2'b11;
    wait_rx(5, 100, "delayed_post");
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (rx_q[i] !== exp_b[i]) begin
        $display("FAIL enable_order[%0d]: got %h required %h", i, rx_q[i], exp_b[i]); n_errors++;
      end
    end
    model_en = 1'b0;
    reset    = 1'b1;
    tick();
    n_checks++;
    if (tx_req !== 1'b0) begin
      $display("FAIL midreset_tx_req: got %b required 0", tx_req); n_errors++;
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (idle !== 1'b1) begin
      $display("FAIL midreset_flush: idle got %b required 1", idle); n_errors++;
    end
    repeat (10) tick();
    n_checks++;
    if (rx_q.size() !== 5) begin
      $display("FAIL midreset_no_tx: got %0d bytes required 5", rx_q.size()); n_errors++;
    end
  endtask

  task automatic test_packet();
    int         stall_sz;
    logic [7:0] exp_b [4];
`ifdef STREAM_MUX_PKTLOCK_EN
    exp_b = '{8'h01, 8'h02, 8'h03, 8'h11};
`else
    exp_b = '{8'h01, 8'h11, 8'h02, 8'h03};
`endif
    ch_en       = 2'b11;
    model_en    = 1'b1;
    busy_cycles = 3;
    clear_rx();
    write_pair(8'h01, 1'b0, 8'h11, 1'b1);
    write_ch(0, 8'h02, 1'b0);
    repeat (50) tick();
    stall_sz = rx_q.size();
    write_ch(0, 8'h03, 1'b1);
    wait_rx(4, 100, "packet");
    n_checks++;
`ifdef STREAM_MUX_PKTLOCK_EN
    if (stall_sz !== 2) begin
      $display("FAIL packet_stall: got %0d bytes during stall required 2", stall_sz); n_errors++;
    end
`else
    if (stall_sz !== 3) begin
      $display("FAIL packet_stall: got %0d bytes during stall required 3", stall_sz); n_errors++;
    end
`endif
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rx_q[i] !== exp_b[i]) begin
        $display("FAIL packet_order[%0d]: got %h required %h", i, rx_q[i], exp_b[i]); n_errors++;
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    ch_en    = 2'b00;
    in_valid = 2'b00;
    in_data  = 16'h0000;
    in_last  = 2'b00;
    test_reset();
    test_single();
    test_fill();
    test_round_robin();
    test_delayed_enable();
    test_packet();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
